// File: rtl/ub_affine_read_port_pkg.sv
// Shared types and defaults for the unified-buffer affine ports.
// Holds the port FSM states, default widths and the ctrl_vars bundle.
package ub_affine_read_port_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 14;
    localparam int DEF_DIMS   = 4;
    localparam int DEF_CTR_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RUN
    } state_e;

    // Loop indices for the default geometry; index 0 is outermost.
    typedef logic [DEF_DIMS-1:0][DEF_CTR_W-1:0] ctrl_vars_t;

endpackage

// File: rtl/ub_affine_read_port_ctr.sv
// Odometer loop-nest counter shared by affine read and write ports.
// Ports: clk, rst_n, clear, step, extent in; ctr, last, advance out.
module affine_loop_ctr
    import ub_affine_read_port_pkg::*;
#(
    parameter int DIMS  = DEF_DIMS,
    parameter int CTR_W = DEF_CTR_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        step,
    input  logic [DIMS-1:0][CTR_W-1:0]  extent,
    output logic [DIMS-1:0][CTR_W-1:0]  ctr,
    output logic                        last,
    output logic [DIMS-1:0]             advance
);

    logic [DIMS-1:0] at_max;
    logic [DIMS-1:0] inc;
    logic            carry;

    always_comb begin
        at_max = '0;
        inc    = '0;
        carry  = 1'b1;
        for (int d = 0; d < DIMS; d++) begin
            // An extent of 0 behaves like 1: the counter never leaves 0.
            at_max[d] = (ctr[d] == ((extent[d] == '0) ? '0
                                    : extent[d] - CTR_W'(1)));
        end
        // Carry ripples from the innermost dimension outward.
        for (int d = DIMS - 1; d >= 0; d--) begin
            inc[d] = carry;
            carry  = carry & at_max[d];
        end
        last    = &at_max;
        advance = step ? inc : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr <= '0;
        end else if (clear) begin
            ctr <= '0;
        end else if (step) begin
            for (int d = 0; d < DIMS; d++) begin
                if (inc[d]) begin
                    ctr[d] <= at_max[d] ? '0 : ctr[d] + CTR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ub_affine_read_port.sv
// Affine-schedule read port: walks a loop nest and streams RAM reads.
// Ports: cfg_* latched on start; mem_* to RAM; out_* / busy / done status.
module ub_affine_read_port
    import ub_affine_read_port_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DIMS   = DEF_DIMS,
    parameter int CTR_W  = DEF_CTR_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        start,
    input  logic [DIMS-1:0][CTR_W-1:0]  cfg_extent,
    input  logic [DIMS-1:0][ADDR_W-1:0] cfg_stride,
    input  logic [ADDR_W-1:0]           cfg_offset,
    input  logic [CTR_W-1:0]            cfg_delay,
    output logic                        mem_ren,
    output logic [ADDR_W-1:0]           mem_raddr,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic [DIMS-1:0][CTR_W-1:0]  out_ctrl_vars,
    output logic                        busy,
    output logic                        done
);

    state_e state_q, state_d;

    logic [DIMS-1:0][CTR_W-1:0]  extent_q;
    logic [DIMS-1:0][ADDR_W-1:0] stride_q;
    logic [ADDR_W-1:0]           offset_q;
    logic [CTR_W-1:0]            delay_q;
    logic [CTR_W-1:0]            dly_q;

    logic [DIMS-1:0][CTR_W-1:0]  ctr;
    logic [DIMS-1:0]             advance;
    logic                        last;
    logic                        run;
    logic                        accept;
    logic                        step;
    logic                        final_read;
    logic [ADDR_W-1:0]           addr;

    assign run    = (state_q == ST_RUN);
    assign accept = (state_q == ST_IDLE) && start && !flush;
    assign step   = run && !flush;

    // Every dimension carries on the final read of the nest.
    assign final_read = (&advance) && last;

    affine_loop_ctr #(
        .DIMS  (DIMS),
        .CTR_W (CTR_W)
    ) u_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept || flush),
        .step    (step),
        .extent  (extent_q),
        .ctr     (ctr),
        .last    (last),
        .advance (advance)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (cfg_delay != '0) ? ST_WAIT : ST_RUN;
                end
            end
            ST_WAIT: begin
                if (dly_q == delay_q - CTR_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (final_read) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            extent_q <= '0;
            stride_q <= '0;
            offset_q <= '0;
            delay_q  <= '0;
            dly_q    <= '0;
        end else if (accept) begin
            extent_q <= cfg_extent;
            stride_q <= cfg_stride;
            offset_q <= cfg_offset;
            delay_q  <= cfg_delay;
            dly_q    <= '0;
        end else if (state_q == ST_WAIT) begin
            dly_q <= dly_q + CTR_W'(1);
        end
    end

    // Address is naturally modulo 2^ADDR_W, so counters are cut to ADDR_W.
    always_comb begin
        addr = offset_q;
        for (int d = 0; d < DIMS; d++) begin
            addr = addr + ADDR_W'(ctr[d]) * stride_q[d];
        end
    end

    assign mem_ren   = run;
    assign mem_raddr = run ? addr : '0;
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = mem_rdata;

    // A flush kills the read issued in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            done          <= 1'b0;
            out_ctrl_vars <= '0;
        end else begin
            out_valid     <= run && !flush;
            done          <= final_read && !flush;
            out_ctrl_vars <= ctr;
        end
    end

endmodule

// File: tb/tb_ub_affine_read_port.sv
// Directed bench for ub_affine_read_port with a behavioural RAM.
// Ports: drives clk/rst_n/cfg/start/flush, checks mem_* and out_*.
module tb_ub_affine_read_port;
    import ub_affine_read_port_pkg::*;

    localparam int AW = DEF_ADDR_W;
    localparam int DW = DEF_DATA_W;
    localparam int DM = DEF_DIMS;
    localparam int CW = DEF_CTR_W;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    flush = 1'b0;
    logic                    start = 1'b0;
    logic [DM-1:0][CW-1:0]   cfg_extent = '0;
    logic [DM-1:0][AW-1:0]   cfg_stride = '0;
    logic [AW-1:0]           cfg_offset = '0;
    logic [CW-1:0]           cfg_delay = '0;
    logic                    mem_ren;
    logic [AW-1:0]           mem_raddr;
    logic [DW-1:0]           mem_rdata;
    logic                    out_valid;
    logic [DW-1:0]           out_data;
    ctrl_vars_t              out_ctrl_vars;
    logic                    busy;
    logic                    done;

    int n_checks = 0;
    int n_fail = 0;

    ub_affine_read_port dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .start         (start),
        .cfg_extent    (cfg_extent),
        .cfg_stride    (cfg_stride),
        .cfg_offset    (cfg_offset),
        .cfg_delay     (cfg_delay),
        .mem_ren       (mem_ren),
        .mem_raddr     (mem_raddr),
        .mem_rdata     (mem_rdata),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ctrl_vars (out_ctrl_vars),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] dat(input logic [AW-1:0] a);
        return {{(DW-AW){1'b0}}, a} ^ 16'h5A5A;
    endfunction

    always @(posedge clk) begin
        mem_rdata <= mem_ren ? dat(mem_raddr) : '0;
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_cfg(
        input logic [CW-1:0] e0, input logic [CW-1:0] e1,
        input logic [CW-1:0] e2, input logic [CW-1:0] e3,
        input logic [AW-1:0] s0, input logic [AW-1:0] s1,
        input logic [AW-1:0] s2, input logic [AW-1:0] s3,
        input logic [AW-1:0] off, input logic [CW-1:0] dly);
        cfg_extent[0] = e0;
        cfg_extent[1] = e1;
        cfg_extent[2] = e2;
        cfg_extent[3] = e3;
        cfg_stride[0] = s0;
        cfg_stride[1] = s1;
        cfg_stride[2] = s2;
        cfg_stride[3] = s3;
        cfg_offset = off;
        cfg_delay = dly;
    endtask

    task automatic test_reset();
        set_cfg(3, 3, 3, 3, 1, 1, 1, 1, 500, 2);
        start = 1'b1;
        #2;
        n_checks++;
        if (mem_ren !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ren_busy got %b/%b exp 0/0", mem_ren, busy);
        end
        n_checks++;
        if (mem_raddr !== '0) begin
            n_fail++;
            $display("FAIL reset_raddr got %0d exp 0", mem_raddr);
        end
        n_checks++;
        if (out_valid !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid_done got %b/%b exp 0/0", out_valid, done);
        end
        n_checks++;
        if (out_ctrl_vars !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %h exp 0", out_ctrl_vars);
        end
        start = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_busy got %b exp 0", busy);
        end
    endtask

    task automatic test_basic_sweep();
        ctrl_vars_t ev;
        int i;
        set_cfg(1, 2, 2, 2, 0, 4, 2, 1, 0, 0);
        start = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            cyc();
            if (c == 1) start = 1'b0;
            n_checks++;
            if (mem_ren !== (c >= 1 && c <= 8)) begin
                n_fail++;
                $display("FAIL basic_ren c=%0d got %b", c, mem_ren);
            end
            if (c >= 1 && c <= 8) begin
                n_checks++;
                if (mem_raddr !== AW'(c - 1)) begin
                    n_fail++;
                    $display("FAIL basic_addr c=%0d got %0d exp %0d",
                             c, mem_raddr, c - 1);
                end
            end
            n_checks++;
            if (out_valid !== (c >= 2 && c <= 9)) begin
                n_fail++;
                $display("FAIL basic_valid c=%0d got %b", c, out_valid);
            end
            if (c >= 2 && c <= 9) begin
                i = c - 2;
                ev = '0;
                ev[1] = CW'((i >> 2) & 1);
                ev[2] = CW'((i >> 1) & 1);
                ev[3] = CW'(i & 1);
                n_checks++;
                if (out_ctrl_vars !== ev) begin
                    n_fail++;
                    $display("FAIL basic_ctrl c=%0d got %h exp %h",
                             c, out_ctrl_vars, ev);
                end
                n_checks++;
                if (out_data !== dat(AW'(i))) begin
                    n_fail++;
                    $display("FAIL basic_data c=%0d got %h exp %h",
                             c, out_data, dat(AW'(i)));
                end
            end
            n_checks++;
            if (done !== (c == 9)) begin
                n_fail++;
                $display("FAIL basic_done c=%0d got %b", c, done);
            end
        end
    endtask

    task automatic test_delay_offset();
        ctrl_vars_t ev;
        set_cfg(1, 1, 1, 4, 0, 0, 0, 1, 100, 3);
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            if (c == 1) start = 1'b0;
            n_checks++;
            if (mem_ren !== (c >= 4 && c <= 7)) begin
                n_fail++;
                $display("FAIL delay_ren c=%0d got %b", c, mem_ren);
            end
            if (c >= 4 && c <= 7) begin
                n_checks++;
                if (mem_raddr !== AW'(100 + c - 4)) begin
                    n_fail++;
                    $display("FAIL delay_addr c=%0d got %0d exp %0d",
                             c, mem_raddr, 100 + c - 4);
                end
            end
            n_checks++;
            if (busy !== (c <= 7)) begin
                n_fail++;
                $display("FAIL delay_busy c=%0d got %b", c, busy);
            end
            if (c >= 5 && c <= 8) begin
                ev = '0;
                ev[3] = CW'(c - 5);
                n_checks++;
                if (out_valid !== 1'b1 || out_ctrl_vars !== ev) begin
                    n_fail++;
                    $display("FAIL delay_ctrl c=%0d got %b/%h exp 1/%h",
                             c, out_valid, out_ctrl_vars, ev);
                end
            end
            n_checks++;
            if (done !== (c == 8)) begin
                n_fail++;
                $display("FAIL delay_done c=%0d got %b", c, done);
            end
        end
    endtask

    task automatic test_addr_wrap();
        set_cfg(1, 1, 1, 2, 0, 0, 0, 1, 16383, 0);
        start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            if (c == 1) start = 1'b0;
            n_checks++;
            if (mem_ren !== (c <= 2)) begin
                n_fail++;
                $display("FAIL wrap_ren c=%0d got %b", c, mem_ren);
            end
            if (c <= 2) begin
                n_checks++;
                if (mem_raddr !== ((c == 1) ? AW'(16383) : AW'(0))) begin
                    n_fail++;
                    $display("FAIL wrap_addr c=%0d got %0d", c, mem_raddr);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (out_data !== dat(AW'(0))) begin
                    n_fail++;
                    $display("FAIL wrap_data got %h exp %h",
                             out_data, dat(AW'(0)));
                end
            end
            n_checks++;
            if (done !== (c == 3)) begin
                n_fail++;
                $display("FAIL wrap_done c=%0d got %b", c, done);
            end
        end
    endtask

    task automatic test_flush();
        set_cfg(1, 2, 2, 2, 0, 4, 2, 1, 0, 0);
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            if (c == 1) start = 1'b0;
            n_checks++;
            if (mem_ren !== (c <= 3) || busy !== (c <= 3)) begin
                n_fail++;
                $display("FAIL flush_ren c=%0d got %b/%b", c, mem_ren, busy);
            end
            n_checks++;
            if (out_valid !== (c >= 2 && c <= 3)) begin
                n_fail++;
                $display("FAIL flush_valid c=%0d got %b", c, out_valid);
            end
            n_checks++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_done c=%0d got %b exp 0", c, done);
            end
            flush = (c == 3);
        end
        start = 1'b1;
        flush = 1'b1;
        cyc();
        start = 1'b0;
        flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || mem_ren !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_prio got %b/%b exp 0/0", busy, mem_ren);
        end
        set_cfg(1, 1, 1, 2, 0, 0, 0, 1, 40, 0);
        start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            if (c == 1) start = 1'b0;
            n_checks++;
            if (mem_ren !== (c <= 2)) begin
                n_fail++;
                $display("FAIL flush_restart_ren c=%0d got %b", c, mem_ren);
            end
            if (c <= 2) begin
                n_checks++;
                if (mem_raddr !== AW'(40 + c - 1)) begin
                    n_fail++;
                    $display("FAIL flush_restart_addr c=%0d got %0d",
                             c, mem_raddr);
                end
            end
            n_checks++;
            if (done !== (c == 3)) begin
                n_fail++;
                $display("FAIL flush_restart_done c=%0d got %b", c, done);
            end
        end
    endtask

    task automatic test_zero_extent();
        set_cfg(0, 0, 0, 0, 3, 3, 3, 3, 77, 0);
        start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            if (c == 1) start = 1'b0;
            n_checks++;
            if (mem_ren !== (c == 1) || busy !== (c == 1)) begin
                n_fail++;
                $display("FAIL zero_ren c=%0d got %b/%b", c, mem_ren, busy);
            end
            if (c == 1) begin
                n_checks++;
                if (mem_raddr !== AW'(77)) begin
                    n_fail++;
                    $display("FAIL zero_addr got %0d exp 77", mem_raddr);
                end
            end
            n_checks++;
            if (out_valid !== (c == 2) || done !== (c == 2)) begin
                n_fail++;
                $display("FAIL zero_done c=%0d got %b/%b", c, out_valid, done);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_ren;
        int a;
        set_cfg(1, 1, 1, 4, 0, 0, 0, 1, 200, 0);
        start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            cyc();
            exp_ren = (c >= 1 && c <= 4) || (c >= 7 && c <= 10);
            a = (c <= 4) ? 200 + c - 1 : 200 + c - 7;
            n_checks++;
            if (mem_ren !== exp_ren) begin
                n_fail++;
                $display("FAIL b2b_ren c=%0d got %b exp %b", c, mem_ren, exp_ren);
            end
            if (exp_ren) begin
                n_checks++;
                if (mem_raddr !== AW'(a)) begin
                    n_fail++;
                    $display("FAIL b2b_addr c=%0d got %0d exp %0d",
                             c, mem_raddr, a);
                end
            end
            n_checks++;
            if (done !== (c == 5 || c == 11)) begin
                n_fail++;
                $display("FAIL b2b_done c=%0d got %b", c, done);
            end
            start = (c == 2 || c == 4 || c == 6);
            if (c == 2) begin
                cfg_offset = 999;
                cfg_extent[3] = 9;
            end
            if (c == 5) begin
                cfg_offset = 200;
                cfg_extent[3] = 4;
            end
        end
    endtask

    task automatic test_async_reset();
        set_cfg(1, 2, 2, 2, 0, 4, 2, 1, 0, 0);
        start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            cyc();
            if (c == 1) start = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_ren !== 1'b0 || busy !== 1'b0 || mem_raddr !== '0) begin
            n_fail++;
            $display("FAIL areset_ren got %b/%b/%0d exp 0/0/0",
                     mem_ren, busy, mem_raddr);
        end
        n_checks++;
        if (out_valid !== 1'b0 || done !== 1'b0 || out_ctrl_vars !== '0) begin
            n_fail++;
            $display("FAIL areset_out got %b/%b/%h exp 0/0/0",
                     out_valid, done, out_ctrl_vars);
        end
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            n_checks++;
            if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL areset_after c=%0d got %b/%b/%b exp 0/0/0",
                         c, done, out_valid, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_delay_offset();
        test_addr_wrap();
        test_flush();
        test_zero_extent();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
